login_verifier: RTL and testbench

- Sequential, parametrised successor to the combinational username/password verifier.
- Holds a programmable table of NUM_USERS credential pairs and searches it one entry per clock after a valid/ready request.
- Counts consecutive failed attempts and enforces a timed lockout after MAX_FAILS.
- Sits between the button/HDMI interface block and the LEDs/status display in the lab top level.

---
 rtl/login_pkg.sv | 14 +
 rtl/lockout_timer.sv | 20 ++
 rtl/login_verifier.sv | 99 +++++++++
 tb/tb_login_verifier.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/login_pkg.sv
// login_pkg: shared types and default parameters for the credential verifier
package login_pkg;
  localparam int DEF_CRED_W = 64;
  localparam int DEF_NUM_USERS = 4;
  localparam int DEF_MAX_FAILS = 3;
  localparam int DEF_LOCK_CYCLES = 100000000;
  typedef enum logic [1:0] {IDLE, SEARCH, RESP, LOCKED} state_t;
  // Table storage is sized to the default width; narrower CRED_W values are zero-extended into it.
  typedef struct packed {
    logic en;
    logic [DEF_CRED_W-1:0] user;
    logic [DEF_CRED_W-1:0] pass;
  } cred_t;
endpackage

// File: rtl/lockout_timer.sv
// lockout_timer: loadable down-counter that flags when the lockout period has elapsed
module lockout_timer
  import login_pkg::*;
#(
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic done
);
  localparam int W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  logic [W-1:0] cnt;
  // Load to LOCK_CYCLES-1 so the zero cycle is the last of LOCK_CYCLES locked cycles.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= W'(LOCK_CYCLES - 1);
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign done = (cnt == '0);
endmodule

// File: rtl/login_verifier.sv
// login_verifier: sequential credential table search with failure counting and timed lockout
module login_verifier
  import login_pkg::*;
#(
  parameter int CRED_W = DEF_CRED_W,
  parameter int NUM_USERS = DEF_NUM_USERS,
  parameter int MAX_FAILS = DEF_MAX_FAILS,
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES,
  parameter int IDX_W = (NUM_USERS > 1) ? $clog2(NUM_USERS) : 1,
  parameter int FAIL_W = $clog2(MAX_FAILS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CRED_W-1:0] username,
  input  logic [CRED_W-1:0] password,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_addr,
  input  logic [CRED_W-1:0] cfg_user,
  input  logic [CRED_W-1:0] cfg_pass,
  input  logic              cfg_en,
  output logic              resp_valid,
  output logic              resp_match,
  output logic [IDX_W-1:0]  resp_index,
  output logic [FAIL_W-1:0] fail_count,
  output logic              locked
);
  state_t state;
  cred_t tbl [NUM_USERS];
  logic [CRED_W-1:0] user_q, pass_q;
  logic [IDX_W-1:0] idx;
  logic hit, last, lock_now, done;
  assign req_ready = (state == IDLE);
  assign hit = tbl[idx].en && tbl[idx].user == DEF_CRED_W'(user_q) && tbl[idx].pass == DEF_CRED_W'(pass_q);
  assign last = (idx == IDX_W'(NUM_USERS - 1));
  assign lock_now = (state == RESP) && !resp_match && (int'(fail_count) + 1 >= MAX_FAILS);
  lockout_timer #(.LOCK_CYCLES(LOCK_CYCLES)) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (lock_now),
    .done (done)
  );
  // Table writes are independent of the FSM; a search always sees the contents registered before this edge.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < NUM_USERS; i++) tbl[i] <= '0;
    else if (cfg_we && int'(cfg_addr) < NUM_USERS)
      tbl[cfg_addr] <= {cfg_en, DEF_CRED_W'(cfg_user), DEF_CRED_W'(cfg_pass)};
  // Request handshake, one-entry-per-cycle search, single-cycle response, and lockout sequencing.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      user_q <= '0;
      pass_q <= '0;
      idx <= '0;
      resp_valid <= 1'b0;
      resp_match <= 1'b0;
      resp_index <= '0;
      fail_count <= '0;
      locked <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE:
          if (req_valid) begin
            user_q <= username;
            pass_q <= password;
            idx <= '0;
            state <= SEARCH;
          end
        SEARCH:
          if (hit || last) begin
            state <= RESP;
            resp_valid <= 1'b1;
            resp_match <= hit;
            resp_index <= hit ? idx : '0;
          end else idx <= idx + 1'b1;
        RESP:
          if (resp_match) begin
            fail_count <= '0;
            state <= IDLE;
          end else if (lock_now) begin
            fail_count <= FAIL_W'(MAX_FAILS);
            locked <= 1'b1;
            state <= LOCKED;
          end else begin
            fail_count <= fail_count + FAIL_W'(1);
            state <= IDLE;
          end
        LOCKED:
          if (done) begin
            fail_count <= '0;
            locked <= 1'b0;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_login_verifier.sv
// tb_login_verifier: directed checks of search latency, failure counting, lockout, reset and table-write races
module tb_login_verifier;
  localparam logic [63:0] ADMIN = 64'h6164_6d69_6e00_0000;
  localparam logic [63:0] APASS = 64'h1234;
  logic clk = 0, rst_n = 0, req_valid = 0, req_ready;
  logic [63:0] username = '0, password = '0, cfg_user = '0, cfg_pass = '0;
  logic cfg_we = 0, cfg_en = 0;
  logic [1:0] cfg_addr = '0;
  logic resp_valid, resp_match, locked;
  logic [1:0] resp_index, fail_count;
  int checks = 0, errors = 0;
  logic m;
  logic [1:0] ix;
  int lat;

  login_verifier #(.LOCK_CYCLES(10)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .username(username), .password(password), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_user(cfg_user), .cfg_pass(cfg_pass), .cfg_en(cfg_en), .resp_valid(resp_valid),
    .resp_match(resp_match), .resp_index(resp_index), .fail_count(fail_count), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [63:0] u, input logic [63:0] p, input logic e);
    cfg_we = 1; cfg_addr = a; cfg_user = u; cfg_pass = p; cfg_en = e;
    step();
    cfg_we = 0;
  endtask

  task automatic wait_ready();
    int w = 0;
    while (!req_ready && w < 50) begin step(); w++; end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL wait_ready: req_ready=%b after %0d cycles, required 1", req_ready, w); end
  endtask

  task automatic do_req(input logic [63:0] u, input logic [63:0] p,
                        output logic mo, output logic [1:0] io, output int lo);
    wait_ready();
    req_valid = 1; username = u; password = p;
    step();
    req_valid = 0;
    lo = 1;
    while (!resp_valid && lo < 50) begin step(); lo++; end
    mo = resp_match;
    io = resp_index;
    step();
  endtask

  task automatic test_reset();
    rst_n = 0;
    step();
    checks += 6;
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    if (resp_match !== 1'b0) begin errors++; $display("FAIL reset_resp_match: got %b want 0", resp_match); end
    if (resp_index !== 2'd0) begin errors++; $display("FAIL reset_resp_index: got %0d want 0", resp_index); end
    if (fail_count !== 2'd0) begin errors++; $display("FAIL reset_fail_count: got %0d want 0", fail_count); end
    if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", locked); end
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    rst_n = 1;
    step();
  endtask

  task automatic test_empty_table();
    do_req(64'd0, 64'd0, m, ix, lat);
    checks += 4;
    if (m !== 1'b0) begin errors++; $display("FAIL empty_match: got %b want 0", m); end
    if (ix !== 2'd0) begin errors++; $display("FAIL empty_index: got %0d want 0", ix); end
    if (lat != 5) begin errors++; $display("FAIL empty_latency: got %0d want 5", lat); end
    if (fail_count !== 2'd1) begin errors++; $display("FAIL empty_fail_count: got %0d want 1", fail_count); end
  endtask

  task automatic test_hit();
    cfg_write(2'd0, 64'd1, 64'd2, 1'b1);
    cfg_write(2'd2, ADMIN, APASS, 1'b1);
    cfg_write(2'd3, 64'd3, 64'd4, 1'b1);
    do_req(ADMIN, APASS, m, ix, lat);
    checks += 4;
    if (m !== 1'b1) begin errors++; $display("FAIL hit2_match: got %b want 1", m); end
    if (ix !== 2'd2) begin errors++; $display("FAIL hit2_index: got %0d want 2", ix); end
    if (lat != 4) begin errors++; $display("FAIL hit2_latency: got %0d want 4", lat); end
    if (fail_count !== 2'd0) begin errors++; $display("FAIL hit2_fail_count: got %0d want 0", fail_count); end
    do_req(64'd1, 64'd2, m, ix, lat);
    checks += 3;
    if (m !== 1'b1) begin errors++; $display("FAIL hit0_match: got %b want 1", m); end
    if (ix !== 2'd0) begin errors++; $display("FAIL hit0_index: got %0d want 0", ix); end
    if (lat != 2) begin errors++; $display("FAIL hit0_latency: got %0d want 2", lat); end
    do_req(64'd3, 64'd4, m, ix, lat);
    checks += 3;
    if (m !== 1'b1) begin errors++; $display("FAIL hit3_match: got %b want 1", m); end
    if (ix !== 2'd3) begin errors++; $display("FAIL hit3_index: got %0d want 3", ix); end
    if (lat != 5) begin errors++; $display("FAIL hit3_latency: got %0d want 5", lat); end
  endtask

  task automatic test_fail_sequence();
    do_req(64'd0, 64'd0, m, ix, lat);
    checks += 3;
    if (m !== 1'b0) begin errors++; $display("FAIL disabled_zero_match: got %b want 0", m); end
    if (fail_count !== 2'd1) begin errors++; $display("FAIL seq_fail1: got %0d want 1", fail_count); end
    if (locked !== 1'b0) begin errors++; $display("FAIL seq_locked1: got %b want 0", locked); end
    do_req(ADMIN, 64'h9999, m, ix, lat);
    checks += 3;
    if (m !== 1'b0) begin errors++; $display("FAIL wrong_pass_match: got %b want 0", m); end
    if (fail_count !== 2'd2) begin errors++; $display("FAIL seq_fail2: got %0d want 2", fail_count); end
    if (locked !== 1'b0) begin errors++; $display("FAIL seq_locked2: got %b want 0", locked); end
    do_req(ADMIN, APASS, m, ix, lat);
    checks += 3;
    if (m !== 1'b1) begin errors++; $display("FAIL seq_success_match: got %b want 1", m); end
    if (fail_count !== 2'd0) begin errors++; $display("FAIL seq_fail0: got %0d want 0", fail_count); end
    if (locked !== 1'b0) begin errors++; $display("FAIL seq_locked3: got %b want 0", locked); end
  endtask

  task automatic test_lockout();
    int n = 0, rv = 0, rd = 0;
    do_req(ADMIN, 64'd7, m, ix, lat);
    do_req(ADMIN, 64'd7, m, ix, lat);
    do_req(ADMIN, 64'd7, m, ix, lat);
    checks += 3;
    if (locked !== 1'b1) begin errors++; $display("FAIL lock_asserted: got %b want 1", locked); end
    if (fail_count !== 2'd3) begin errors++; $display("FAIL lock_fail_count: got %0d want 3", fail_count); end
    if (req_ready !== 1'b0) begin errors++; $display("FAIL lock_req_ready: got %b want 0", req_ready); end
    while (locked && n < 100) begin
      rv += resp_valid;
      rd += req_ready;
      step();
      n++;
    end
    checks += 5;
    if (n != 10) begin errors++; $display("FAIL lock_duration: got %0d cycles want 10", n); end
    if (rv != 0) begin errors++; $display("FAIL lock_resp_valid: got %0d pulses want 0", rv); end
    if (rd != 0) begin errors++; $display("FAIL lock_ready_seen: got %0d cycles want 0", rd); end
    if (fail_count !== 2'd0) begin errors++; $display("FAIL unlock_fail_count: got %0d want 0", fail_count); end
    if (req_ready !== 1'b1) begin errors++; $display("FAIL unlock_req_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_cfg_race();
    wait_ready();
    req_valid = 1; username = ADMIN; password = APASS;
    step();
    req_valid = 0;
    step();
    step();
    cfg_we = 1; cfg_addr = 2'd2; cfg_user = ADMIN; cfg_pass = APASS; cfg_en = 0;
    step();
    cfg_we = 0;
    checks += 3;
    if (resp_valid !== 1'b1) begin errors++; $display("FAIL race_resp_valid: got %b want 1", resp_valid); end
    if (resp_match !== 1'b1) begin errors++; $display("FAIL race_match: got %b want 1", resp_match); end
    if (resp_index !== 2'd2) begin errors++; $display("FAIL race_index: got %0d want 2", resp_index); end
    step();
    do_req(ADMIN, APASS, m, ix, lat);
    checks++;
    if (m !== 1'b0) begin errors++; $display("FAIL race_disabled_match: got %b want 0", m); end
  endtask

  task automatic test_reset_mid();
    int rv = 0;
    do_req(64'd9, 64'd9, m, ix, lat);
    wait_ready();
    req_valid = 1; username = 64'd3; password = 64'd4;
    step();
    req_valid = 0;
    step();
    rst_n = 0;
    #1;
    checks += 3;
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_search_resp_valid: got %b want 0", resp_valid); end
    if (fail_count !== 2'd0) begin errors++; $display("FAIL rst_search_fail_count: got %0d want 0", fail_count); end
    if (locked !== 1'b0) begin errors++; $display("FAIL rst_search_locked: got %b want 0", locked); end
    step();
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin rv += resp_valid; step(); end
    checks++;
    if (rv != 0) begin errors++; $display("FAIL rst_search_no_resp: got %0d pulses want 0", rv); end
    do_req(64'd3, 64'd4, m, ix, lat);
    checks += 2;
    if (m !== 1'b0) begin errors++; $display("FAIL rst_table_cleared: got %b want 0", m); end
    if (fail_count !== 2'd1) begin errors++; $display("FAIL rst_after_fail_count: got %0d want 1", fail_count); end
    do_req(64'd3, 64'd4, m, ix, lat);
    do_req(64'd3, 64'd4, m, ix, lat);
    step();
    step();
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL rst_pre_locked: got %b want 1", locked); end
    rst_n = 0;
    #1;
    checks += 4;
    if (locked !== 1'b0) begin errors++; $display("FAIL rst_lock_locked: got %b want 0", locked); end
    if (fail_count !== 2'd0) begin errors++; $display("FAIL rst_lock_fail_count: got %0d want 0", fail_count); end
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_lock_resp_valid: got %b want 0", resp_valid); end
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_lock_req_ready: got %b want 1", req_ready); end
    step();
    rst_n = 1;
    step();
  endtask

  initial begin
    test_reset();
    test_empty_table();
    test_hit();
    test_fail_sequence();
    test_lockout();
    test_cfg_race();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
